fir_datapath: RTL and testbench

Execution datapath for the FIR filter accelerator: a 16-entry register file plus ALU. It carries out one controller micro-op per clock, selected by `op`, `src1`, `src2` and `dest`. It reports `overflow` back to the controller in the same cycle the op is presented, and exposes register 0 as the filter result. It sits between the FIR controller FSM and the AHB-Lite slave, which supplies the sample and coefficient data words.

---
 rtl/fir_datapath.sv | 98 +++++++++
 tb/tb_fir_datapath.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_datapath.sv
// Execution datapath for the FIR accelerator: 16-entry signed register file plus
// single-cycle ALU (copy/load/add/sub/Q1.15 multiply) with combinational overflow.
module fir_datapath #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        op,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] ext_data1,
  input  logic [DATA_W-1:0] ext_data2,
  output logic              overflow,
  output logic [DATA_W-1:0] outreg_data
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_COPY  = 3'b001,
    OP_LOAD1 = 3'b010,
    OP_LOAD2 = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  logic        [DATA_W-1:0]   regs [16];
  logic signed [DATA_W-1:0]   opa;
  logic signed [DATA_W-1:0]   opb;
  logic        [DATA_W-1:0]   sum;
  logic        [DATA_W-1:0]   diff;
  logic signed [2*DATA_W-1:0] prod;
  logic        [DATA_W:0]     prod_scaled;
  logic        [DATA_W-1:0]   result;
  logic                       wr_en;
  op_e                        op_sel;

  assign op_sel = op_e'(op);
  assign opa    = regs[src1];
  assign opb    = regs[src2];
  assign sum    = opa + opb;
  assign diff   = opa - opb;
  assign prod   = opa * opb;
  // Keep P[31:15]: low DATA_W bits are the Q1.15 result, top bit checks sign loss.
  assign prod_scaled = (DATA_W+1)'(prod >>> (DATA_W-1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    result   = '0;
    wr_en    = 1'b0;
    overflow = 1'b0;
    unique case (op_sel)
      OP_COPY: begin
        result = opa;
        wr_en  = 1'b1;
      end
      OP_LOAD1: begin
        result = ext_data1;
        wr_en  = 1'b1;
      end
      OP_LOAD2: begin
        result = ext_data2;
        wr_en  = 1'b1;
      end
      OP_ADD: begin
        result   = sum;
        wr_en    = 1'b1;
        overflow = (opa[DATA_W-1] == opb[DATA_W-1]) && (sum[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_SUB: begin
        result   = diff;
        wr_en    = 1'b1;
        overflow = (opa[DATA_W-1] != opb[DATA_W-1]) && (diff[DATA_W-1] != opa[DATA_W-1]);
      end
      OP_MUL: begin
        result   = prod_scaled[DATA_W-1:0];
        wr_en    = 1'b1;
        overflow = prod_scaled[DATA_W] ^ prod_scaled[DATA_W-1];
      end
      default: ;
    endcase
  end

  // NOTE: the register file is reset entry by entry because a reset must discard
  // any partial accumulation; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[dest] <= result;
    end
  end

  assign outreg_data = regs[0];

endmodule

// File: tb/tb_fir_datapath.sv
// Directed bench for fir_datapath: a behavioural register-file model feeds a
// scoreboard queue of expected R0 values, plus constant checks of key results.
module tb_fir_datapath;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [2:0]  op;
  logic [3:0]  src1, src2, dest;
  logic [15:0] ext_data1, ext_data2;
  logic        overflow;
  logic [15:0] outreg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] m [16];
  logic [15:0]        sb_q [$];
  logic               last_ov;

  localparam logic [2:0] NOP = 3'd0, COPY = 3'd1, LD1 = 3'd2, LD2 = 3'd3,
                         ADD = 3'd4, SUB = 3'd5, MUL = 3'd6, RSV = 3'd7;

  fir_datapath #(.DATA_W(16)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .op         (op),
    .src1       (src1),
    .src2       (src2),
    .dest       (dest),
    .ext_data1  (ext_data1),
    .ext_data2  (ext_data2),
    .overflow   (overflow),
    .outreg_data(outreg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op, check overflow against the model mid-cycle, and compare R0
  // against the scoreboard after the edge.
  task automatic do_op(input string tag, input logic rst, input logic [2:0] o,
                       input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input logic [15:0] e1, input logic [15:0] e2);
    logic signed [15:0] a, b;
    int     r;
    longint p;
    logic   w, ov;
    @(negedge clk);
    n_rst = rst; op = o; src1 = s1; src2 = s2; dest = d;
    ext_data1 = e1; ext_data2 = e2;
    #1;
    a = m[s1]; b = m[s2]; r = 0; w = 1'b1; ov = 1'b0;
    case (o)
      COPY: r = int'(a);
      LD1:  r = int'($signed(e1));
      LD2:  r = int'($signed(e2));
      ADD: begin
        r  = int'(a) + int'(b);
        ov = (r > 32767) || (r < -32768);
      end
      SUB: begin
        r  = int'(a) - int'(b);
        ov = (r > 32767) || (r < -32768);
      end
      MUL: begin
        p  = longint'(a) * longint'(b);
        r  = int'(p >>> 15);
        ov = (p >= (64'sd1 <<< 30)) || (p < -(64'sd1 <<< 30));
      end
      default: w = 1'b0;
    endcase
    check({tag, "_ovf"}, {15'd0, overflow}, {15'd0, ov});
    last_ov = overflow;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m[i] = '0;
    end else if (w) begin
      m[d] = r[15:0];
    end
    sb_q.push_back(m[0]);
    @(posedge clk);
    #1;
    check({tag, "_r0"}, outreg_data, sb_q.pop_front());
  endtask

  task automatic ld1(input logic [3:0] d, input logic [15:0] v);
    do_op("ld1", 1'b1, LD1, 4'd0, 4'd0, d, v, 16'h0);
  endtask

  task automatic ld2(input logic [3:0] d, input logic [15:0] v);
    do_op("ld2", 1'b1, LD2, 4'd0, 4'd0, d, 16'h0, v);
  endtask

  task automatic alu(input string tag, input logic [2:0] o, input logic [3:0] s1,
                     input logic [3:0] s2, input logic [3:0] d);
    do_op(tag, 1'b1, o, s1, s2, d, 16'h0, 16'h0);
  endtask

  // COPY a register into R0 and check it against a spec-derived constant.
  task automatic read_reg(input string tag, input logic [3:0] idx, input logic [15:0] exp);
    alu(tag, COPY, idx, 4'd0, 4'd0);
    check(tag, outreg_data, exp);
  endtask

  task automatic shift_in(input logic [15:0] s);
    ld1(4'd5, s);
    alu("sh21", COPY, 4'd2, 4'd0, 4'd1);
    alu("sh32", COPY, 4'd3, 4'd0, 4'd2);
    alu("sh43", COPY, 4'd4, 4'd0, 4'd3);
    alu("sh54", COPY, 4'd5, 4'd0, 4'd4);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m[i] = '0;
    n_rst = 1'b0; op = LD2; src1 = '0; src2 = '0; dest = 4'd6;
    ext_data1 = '0; ext_data2 = 16'h1234;

    // Reset with a LOAD2 presented: the write must be suppressed.
    do_op("rst0", 1'b0, LD2, 4'd0, 4'd0, 4'd6, 16'h0, 16'h1234);
    do_op("rst1", 1'b0, LD2, 4'd0, 4'd0, 4'd6, 16'h0, 16'h1234);
    check("reset_out", outreg_data, 16'h0000);
    read_reg("r6_after_rst", 4'd6, 16'h0000);
    ld2(4'd6, 16'h4000);
    read_reg("r6_load2", 4'd6, 16'h4000);

    // MUL Q1.15 scaling and the -1 * -1 overflow corner.
    ld1(4'd1, 16'h0100);
    ld2(4'd9, 16'h4000);
    alu("mul_half", MUL, 4'd1, 4'd9, 4'd10);
    check("mul_half_ov", {15'd0, last_ov}, 16'd0);
    read_reg("r10_half", 4'd10, 16'h0080);
    ld1(4'd1, 16'h8000);
    ld2(4'd9, 16'h8000);
    alu("mul_ovf", MUL, 4'd1, 4'd9, 4'd10);
    check("mul_ovf_ov", {15'd0, last_ov}, 16'd1);
    read_reg("r10_ovf", 4'd10, 16'h8000);

    // ADD overflow and its non-overflowing neighbour.
    ld1(4'd0, 16'h7FFF);
    ld1(4'd10, 16'h0001);
    alu("add_ovf", ADD, 4'd0, 4'd10, 4'd0);
    check("add_ovf_ov", {15'd0, last_ov}, 16'd1);
    check("add_ovf_res", outreg_data, 16'h8000);
    ld1(4'd0, 16'h7FFF);
    ld1(4'd10, 16'hFFFF);
    alu("add_ok", ADD, 4'd0, 4'd10, 4'd0);
    check("add_ok_ov", {15'd0, last_ov}, 16'd0);
    check("add_ok_res", outreg_data, 16'h7FFE);

    // SUB overflow and a plain negative result.
    ld1(4'd0, 16'h8000);
    ld1(4'd10, 16'h0001);
    alu("sub_ovf", SUB, 4'd0, 4'd10, 4'd0);
    check("sub_ovf_ov", {15'd0, last_ov}, 16'd1);
    check("sub_ovf_res", outreg_data, 16'h7FFF);
    ld1(4'd0, 16'h0005);
    ld1(4'd10, 16'h0007);
    alu("sub_ok", SUB, 4'd0, 4'd10, 4'd0);
    check("sub_ok_ov", {15'd0, last_ov}, 16'd0);
    check("sub_ok_res", outreg_data, 16'hFFFE);

    // Reserved op and NOP must leave R0 alone; R15 is writable.
    alu("rsvd", RSV, 4'd10, 4'd10, 4'd0);
    check("rsvd_hold", outreg_data, 16'hFFFE);
    alu("nop", NOP, 4'd10, 4'd10, 4'd0);
    ld1(4'd15, 16'hBEEF);
    read_reg("r15", 4'd15, 16'hBEEF);

    // Shift history through R1..R4 and dest==src1 hazard.
    shift_in(16'h0011);
    shift_in(16'h0022);
    shift_in(16'h0033);
    shift_in(16'h0044);
    read_reg("hist_r1", 4'd1, 16'h0011);
    read_reg("hist_r2", 4'd2, 16'h0022);
    read_reg("hist_r3", 4'd3, 16'h0033);
    read_reg("hist_r4", 4'd4, 16'h0044);
    ld1(4'd3, 16'h0010);
    alu("dbl", ADD, 4'd3, 4'd3, 4'd3);
    read_reg("dbl_r3", 4'd3, 16'h0020);

    // Full FIR tap sequence with 0.25 coefficients.
    for (int i = 6; i <= 9; i++) ld2(4'(i), 16'h2000);
    shift_in(16'h0100);
    shift_in(16'h0200);
    shift_in(16'h0300);
    shift_in(16'h0400);
    alu("zero", SUB, 4'd0, 4'd0, 4'd0);
    alu("m1", MUL, 4'd1, 4'd6, 4'd10);
    alu("a1", ADD, 4'd0, 4'd10, 4'd0);
    alu("m2", MUL, 4'd2, 4'd7, 4'd10);
    alu("s2", SUB, 4'd0, 4'd10, 4'd0);
    alu("m3", MUL, 4'd3, 4'd8, 4'd10);
    alu("a3", ADD, 4'd0, 4'd10, 4'd0);
    alu("m4", MUL, 4'd4, 4'd9, 4'd10);
    alu("s4", SUB, 4'd0, 4'd10, 4'd0);
    check("fir_result", outreg_data, 16'hFF80);

    // Mid-sequence reset discards accumulation, even with an ADD presented.
    do_op("midrst", 1'b0, ADD, 4'd0, 4'd10, 4'd0, 16'h0, 16'h0);
    check("midrst_r0", outreg_data, 16'h0000);
    read_reg("midrst_r10", 4'd10, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
